// File: rtl/cpu_defs.sv
// ============================================================================
// Package     : cpu_defs
// Description : Definitions shared by the fetch stage, memory stage and the
//               memory port arbiter: arbiter FSM state encodings and the
//               default address/data widths of the CPU memory interfaces.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_defs;

  // Default interface widths shared with the fetch and memory stages
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Memory port arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_INST = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

endpackage : cpu_defs

`default_nettype wire

// File: rtl/arb_starve_cnt.sv
// ============================================================================
// Module      : arb_starve_cnt
// Description : Saturating counter that tracks how many data grants were
//               issued while an instruction fetch was left waiting.
//               Counts 0..MAX and holds at MAX until cleared.
// Ports       : clk    in  clock, rising edge
//               resetn in  asynchronous active-low reset
//               clr    in  synchronous clear (wins over inc)
//               inc    in  count one event
//               at_max out counter has reached MAX
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt;

  assign at_max = (cnt == CNT_W'(MAX));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : arb_starve_cnt

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single external memory port between instruction
//               fetch (IF) and load/store (MEM). A 3-state FSM serialises the
//               requesters; data wins ties because MEM holds the older
//               instruction. stall_if/stall_mem freeze the pipeline while the
//               matching access is outstanding.
// Options     : MEM_ARB_FAIR_EN - when defined, a starvation counter forces
//               an instruction grant after STARVE_MAX consecutive data grants
//               issued while inst_req was pending.
// Ports       : clk, resetn (async, active-low)
//               inst_req/inst_addr -> inst_rdata/inst_ready   (IF side)
//               data_req/data_wr/data_wstrb/data_addr/data_wdata
//                 -> data_rdata/data_ready                     (MEM side)
//               mem_req/mem_wr/mem_wstrb/mem_addr/mem_wdata,
//                 mem_rdata/mem_ack                            (bus side)
//               stall_if, stall_mem                            (hazard unit)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  // Instruction fetch side
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ready,
  // Load/store side
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ready,
  // External memory bus
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  // Hazard unit
  output logic                stall_if,
  output logic                stall_mem
);

  localparam int STRB_W = DATA_W / 8;

  // The starvation counter needs at least one slot; checked in every build.
  if (STARVE_MAX < 1) begin : g_param_check
    $error("mem_port_arbiter: STARVE_MAX must be >= 1");
  end

  arb_state_t state, state_nxt;

  logic              bus_wr;
  logic [STRB_W-1:0] bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;

  logic grant_inst;
  logic grant_data;
  logic force_inst;

  // --------------------------------------------------------------------------
  // Optional fairness: force an instruction grant after STARVE_MAX data grants
  // taken while the fetch was waiting.
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_FAIR_EN
  logic starve_clr;
  logic starve_inc;
  logic starve_at_max;

  assign starve_clr = (state == ARB_IDLE) && (grant_inst || !inst_req);
  assign starve_inc = grant_data && inst_req;

  arb_starve_cnt #(
    .MAX    (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .at_max (starve_at_max)
  );

  // Only force when there is a fetch to grant, otherwise data must still win.
  assign force_inst = starve_at_max && inst_req;
`else
  assign force_inst = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM next state and grant decode; arbitration happens only in IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (data_req && !force_inst) begin
          grant_data = 1'b1;
          state_nxt  = ARB_DATA;
        end else if (inst_req) begin
          grant_inst = 1'b1;
          state_nxt  = ARB_INST;
        end
      end
      ARB_INST, ARB_DATA: begin
        // Always return to IDLE after the ack so the requester can drop or
        // replace its request before the next arbitration.
        if (mem_ack) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and bus registers latched on the grant.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ARB_IDLE;
      bus_wr    <= 1'b0;
      bus_wstrb <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (grant_data) begin
        bus_wr    <= data_wr;
        bus_wstrb <= data_wr ? data_wstrb : '0;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end else if (grant_inst) begin
        bus_wr    <= 1'b0;
        bus_wstrb <= '0;
        bus_addr  <= inst_addr;
        bus_wdata <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. mem_req decodes straight from the state register so it drops as
  // soon as resetn is asserted.
  // --------------------------------------------------------------------------
  assign mem_req   = (state != ARB_IDLE);
  assign mem_wr    = bus_wr;
  assign mem_wstrb = bus_wstrb;
  assign mem_addr  = bus_addr;
  assign mem_wdata = bus_wdata;

  // Ready is combinational on the ack; an ack seen in IDLE matches no state.
  assign inst_ready = (state == ARB_INST) && mem_ack;
  assign data_ready = (state == ARB_DATA) && mem_ack;
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign stall_if  = inst_req && !inst_ready;
  assign stall_mem = data_req && !data_ready;

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. Inputs
//               change 1 ns after the rising edge, outputs are sampled on the
//               falling edge. The long-contention step expects strict data
//               priority, or the 4-data/1-inst rotation when MEM_ARB_FAIR_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_ready;
  logic          data_req;
  logic          data_wr;
  logic [3:0]    data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_ready;
  logic          mem_req;
  logic          mem_wr;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          stall_if;
  logic          stall_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ready (inst_ready),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_wstrb (data_wstrb),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_ready (data_ready),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_wstrb  (mem_wstrb),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge (input drive point).
  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next falling edge (sample point).
  task automatic sample_pt();
    @(negedge clk);
  endtask

  initial begin
    logic exp_inst;

    resetn     = 1'b0;
    inst_req   = 1'b1;
    inst_addr  = '0;
    data_req   = 1'b1;
    data_wr    = 1'b0;
    data_wstrb = '0;
    data_addr  = '0;
    data_wdata = '0;
    mem_rdata  = '0;
    mem_ack    = 1'b1;

    // ---------------- Reset with both requests and a stray ack ----------------
    repeat (2) sample_pt();
    chk("rst_mem_req",    mem_req,    1'b0);
    chk("rst_mem_wr",     mem_wr,     1'b0);
    chk("rst_mem_wstrb",  mem_wstrb,  4'h0);
    chk("rst_inst_ready", inst_ready, 1'b0);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_stall_if",   stall_if,   1'b1);
    chk("rst_stall_mem",  stall_mem,  1'b1);

    drive_pt();
    inst_req = 1'b0;
    data_req = 1'b0;
    mem_ack  = 1'b0;
    drive_pt();
    resetn = 1'b1;

    // ---------------- Lone fetch, ack 2 cycles after mem_req ----------------
    drive_pt();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0040;
    sample_pt();
    chk("fetch_idle_req", mem_req,  1'b0);
    chk("fetch_stall0",   stall_if, 1'b1);
    drive_pt();                       // now in INST, mem_req rose
    sample_pt();
    chk("fetch_mem_req",  mem_req,    1'b1);
    chk("fetch_addr",     mem_addr,   32'h40);
    chk("fetch_wr",       mem_wr,     1'b0);
    chk("fetch_wstrb",    mem_wstrb,  4'h0);
    chk("fetch_noready1", inst_ready, 1'b0);
    drive_pt();
    sample_pt();
    chk("fetch_noready2", inst_ready, 1'b0);
    chk("fetch_stall2",   stall_if,   1'b1);
    drive_pt();
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    sample_pt();
    chk("fetch_ready",    inst_ready, 1'b1);
    chk("fetch_rdata",    inst_rdata, 32'h1234_5678);
    chk("fetch_stall_lo", stall_if,   1'b0);
    chk("fetch_no_dready", data_ready, 1'b0);
    drive_pt();
    inst_req = 1'b0;
    mem_ack  = 1'b0;
    sample_pt();
    chk("fetch_back_idle", mem_req, 1'b0);

    // ---------------- Contention: DATA, IDLE bubble, then INST ----------------
    drive_pt();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0080;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0200;
    drive_pt();                       // DATA granted; ack with zero latency
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    sample_pt();
    chk("cont_d_addr",    mem_addr,   32'h200);
    chk("cont_d_wr",      mem_wr,     1'b0);
    chk("cont_d_ready",   data_ready, 1'b1);
    chk("cont_d_rdata",   data_rdata, 32'hCAFE_0001);
    chk("cont_d_iready",  inst_ready, 1'b0);
    chk("cont_d_stallif", stall_if,   1'b1);
    drive_pt();                       // IDLE bubble, ack ignored here
    data_req = 1'b0;
    sample_pt();
    chk("cont_bub_req",   mem_req,    1'b0);
    chk("cont_bub_iready", inst_ready, 1'b0);
    chk("cont_bub_stall", stall_if,   1'b1);
    drive_pt();                       // INST granted
    mem_rdata = 32'hCAFE_0002;
    sample_pt();
    chk("cont_i_addr",    mem_addr,   32'h80);
    chk("cont_i_ready",   inst_ready, 1'b1);
    chk("cont_i_rdata",   inst_rdata, 32'hCAFE_0002);
    chk("cont_i_dready",  data_ready, 1'b0);
    drive_pt();
    inst_req = 1'b0;
    mem_ack  = 1'b0;

    // ---------------- Store ----------------
    drive_pt();
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_wstrb = 4'b0011;
    data_addr  = 32'h0000_0100;
    data_wdata = 32'hDEAD_BEEF;
    drive_pt();
    sample_pt();
    chk("st_mem_req", mem_req,    1'b1);
    chk("st_wr",      mem_wr,     1'b1);
    chk("st_wstrb",   mem_wstrb,  4'b0011);
    chk("st_addr",    mem_addr,   32'h100);
    chk("st_wdata",   mem_wdata,  32'hDEAD_BEEF);
    chk("st_noready", data_ready, 1'b0);
    chk("st_stall",   stall_mem,  1'b1);
    drive_pt();
    mem_ack = 1'b1;
    sample_pt();
    chk("st_ready",    data_ready, 1'b1);
    chk("st_stall_lo", stall_mem,  1'b0);
    drive_pt();
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = '0;
    mem_ack    = 1'b0;

    // Fetch right after a store must drive wr=0, wstrb=0
    drive_pt();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0044;
    drive_pt();
    sample_pt();
    chk("post_st_wr",    mem_wr,    1'b0);
    chk("post_st_wstrb", mem_wstrb, 4'h0);
    chk("post_st_addr",  mem_addr,  32'h44);
    drive_pt();
    mem_ack = 1'b1;
    drive_pt();
    inst_req = 1'b0;
    mem_ack  = 1'b0;

    // ---------------- Abort by reset mid-DATA ----------------
    drive_pt();
    data_req  = 1'b1;
    data_addr = 32'h0000_0300;
    drive_pt();
    chk("abort_req_hi", mem_req, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_req_async", mem_req,    1'b0);
    chk("abort_noready",   data_ready, 1'b0);
    chk("abort_stall",     stall_mem,  1'b1);
    drive_pt();
    data_req = 1'b0;
    drive_pt();
    resetn = 1'b1;
    drive_pt();
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    sample_pt();
    chk("late_ack_dready", data_ready, 1'b0);
    chk("late_ack_iready", inst_ready, 1'b0);
    chk("late_ack_req",    mem_req,    1'b0);
    drive_pt();
    mem_ack = 1'b0;
    sample_pt();
    chk("late_ack_idle", mem_req, 1'b0);

    // ---------------- Both requests held continuously ----------------
    drive_pt();
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0400;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0500;
    mem_ack   = 1'b1;                 // ack every busy cycle; ignored in IDLE
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIR_EN
      exp_inst = ((k % 5) == 4);
`else
      exp_inst = 1'b0;
`endif
      drive_pt();
      sample_pt();
      chk($sformatf("hold_g%0d_inst", k), inst_ready, exp_inst);
      chk($sformatf("hold_g%0d_data", k), data_ready, !exp_inst);
      drive_pt();
      sample_pt();
      chk($sformatf("hold_g%0d_bubble", k), mem_req, 1'b0);
    end
    drive_pt();
    inst_req = 1'b0;
    data_req = 1'b0;
    mem_ack  = 1'b0;
    repeat (2) drive_pt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire
